regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with registered read ports, write-to-read bypass and a per-register busy scoreboard. It is the next-generation register file for the scpu datapath and sits between decode (read/allocate) and writeback (write). The scoreboard lets multi-cycle producers reserve a destination so that consumers stall until the result lands.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 4, number of architectural registers (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register index width (derived)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- wen  in  1  write enable (writeback port)
- rd  in  ADDR_W  write destination index
- data  in  DATA_W  write data
- rd_req  in  1  read request for rs1/rs2 this cycle
- rs1, rs2  in  ADDR_W  read source indices
- q1, q2  out  DATA_W  registered read data
- q_valid  out  1  q1/q2 hold data for the request accepted last cycle
- stall  out  1  combinational: the request cannot be accepted this cycle
- alloc_en  in  1  reserve a destination (marks it busy)
- alloc_rd  in  ADDR_W  index to reserve
- alloc_conflict  out  1  one-cycle pulse: allocation targeted an already-busy register
- busy  out  NUM_REGS  scoreboard bits, bit i = register i pending
- regs_flat  out  NUM_REGS*DATA_W  debug view; register i at bits [i*DATA_W +: DATA_W]

## Operation
- Write: when wen, reg[rd] <= data at the edge; this also clears busy[rd].
- Source hazard: src_busy(s) = busy[s] && !(wen && rd == s).
- stall = rd_req && (src_busy(rs1) || src_busy(rs2)).
- Read accept: on rd_req && !stall, q1/q2 load the selected values and q_valid is 1 next cycle. Otherwise q_valid is 0 and q1/q2 hold their previous values.
- Bypass: if wen && rd == rs1 in the accept cycle, q1 loads data instead of reg[rs1]. The same rule applies to rs2/q2.
- Allocate: alloc_en sets busy[alloc_rd] at the edge.
  - If busy[alloc_rd] is already 1 and it is not cleared by a same-cycle write, alloc_conflict pulses and the bit stays 1.
- Write and allocate to the same index in one cycle: the data is written and busy ends at 1, because allocation wins (a new producer is now pending).
- A write to a non-busy register is legal; busy is unchanged.
- rs1 == rs2 is legal; both outputs carry identical data.

## Timing
- Read latency: 1 cycle from accept to q_valid/q1/q2.
- stall is combinational from rd_req, rs1, rs2, wen, rd and busy. It has no path from alloc_en; a same-cycle allocation affects only the next cycle.
- Write-to-read visibility:
  - same-cycle read gets the data through the bypass;
  - the register array is updated at the same edge.
- Reset (synchronous, at any time, including with an outstanding read):
  - all registers 0, busy 0;
  - q1 = q2 = 0, q_valid = 0, alloc_conflict = 0;
  - inputs sampled in the reset cycle are ignored.
- stall and regs_flat reflect reset state in the cycle after the reset edge.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - register 0 reads constant 0 and writes to it are discarded;
  - busy[0] is forced to 0 and alloc to index 0 is ignored (no conflict pulse);
  - the bypass never forwards to index 0, and regs_flat shows 0 for it.
- REGFILE_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_W and NUM_REGS constants;
  - the ADDR_W derivation function;
  - the scpu register-index typedef.
- Sub-module rf_scoreboard holds:
  - the busy vector, set/clear priority, conflict pulse and stall computation.
- The top level holds the register array, bypass mux and read-output registers.

## Test plan
- Reset, then read r0..r3 (default params) -> q_valid 1 one cycle after rd_req, q1 = q2 = 0x00.
- Write 0xA5 to r2 and read rs1 = 2 in the same cycle -> q1 = 0xA5 next cycle (bypass); regs_flat[23:16] = 0xA5.
- Alloc r1, then rd_req rs2 = 1 for 3 cycles -> stall high and q_valid 0 throughout.
  - Then wen rd = 1, data 0x3C with rd_req still high -> stall drops that cycle and q2 = 0x3C next cycle.
- Alloc r3 twice without an intervening write -> alloc_conflict pulses for exactly one cycle and busy[3] stays 1.
- Write and alloc to r0 in the same cycle (macro off) -> reg0 updated and busy[0] = 1.
  - With REGFILE_ZERO_REG_EN: reg0 reads 0 and busy[0] = 0.
- Assert rst while q_valid = 1 and busy = 4'b1010 -> next cycle all outputs are 0, busy = 0 and stall = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scpu register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 8;
  localparam int unsigned DEFAULT_NUM_REGS = 4;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return $clog2(num_regs);
  endfunction

  localparam int unsigned DEFAULT_ADDR_W = addr_w(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_ADDR_W-1:0] scpu_reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of regfile_sb; master = datapath, slave = register file.
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS
);
  localparam int unsigned ADDR_W = addr_w(NUM_REGS);

  logic                       wen;
  logic [ADDR_W-1:0]          rd;
  logic [DATA_W-1:0]          data;
  logic                       rd_req;
  logic [ADDR_W-1:0]          rs1;
  logic [ADDR_W-1:0]          rs2;
  logic [DATA_W-1:0]          q1;
  logic [DATA_W-1:0]          q2;
  logic                       q_valid;
  logic                       stall;
  logic                       alloc_en;
  logic [ADDR_W-1:0]          alloc_rd;
  logic                       alloc_conflict;
  logic [NUM_REGS-1:0]        busy;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  modport master (
    output wen, rd, data, rd_req, rs1, rs2, alloc_en, alloc_rd,
    input  q1, q2, q_valid, stall, alloc_conflict, busy, regs_flat
  );

  modport slave (
    input  wen, rd, data, rd_req, rs1, rs2, alloc_en, alloc_rd,
    output q1, q2, q_valid, stall, alloc_conflict, busy, regs_flat
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: allocate sets, write clears (allocate wins), conflict pulse, read stall.
// REGFILE_ZERO_REG_EN: index 0 can never become busy.
module rf_scoreboard import regfile_pkg::*; #(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall,
  output logic                alloc_conflict
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;
  logic                conflict_next;
  logic                src1_busy;
  logic                src2_busy;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      set_vec[i] = alloc_en && (alloc_rd == ADDR_W'(i));
      clr_vec[i] = wen && (rd == ADDR_W'(i));
    end
`ifdef REGFILE_ZERO_REG_EN
    set_vec[0] = 1'b0;
`endif
    // Set is ORed after the clear so a same-cycle allocate keeps the bit pending.
    busy_next     = (busy & ~clr_vec) | set_vec;
    conflict_next = set_vec[alloc_rd] && busy[alloc_rd] && !clr_vec[alloc_rd];
    src1_busy     = busy[rs1] && !clr_vec[rs1];
    src2_busy     = busy[rs2] && !clr_vec[rs2];
    stall         = rd_req && (src1_busy || src2_busy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      alloc_conflict <= 1'b0;
    end else begin
      busy           <= busy_next;
      alloc_conflict <= conflict_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with registered reads, write-to-read bypass and busy scoreboard.
// REGFILE_ZERO_REG_EN: register 0 is hard-wired to zero.
module regfile_sb import regfile_pkg::*; #(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned ADDR_W = addr_w(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_val1;
  logic [DATA_W-1:0] rd_val2;
  logic              wr_en;
  logic              accept;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .wen            (bus.wen),
    .rd             (bus.rd),
    .rd_req         (bus.rd_req),
    .rs1            (bus.rs1),
    .rs2            (bus.rs2),
    .alloc_en       (bus.alloc_en),
    .alloc_rd       (bus.alloc_rd),
    .busy           (bus.busy),
    .stall          (bus.stall),
    .alloc_conflict (bus.alloc_conflict)
  );

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    wr_en = bus.wen && (bus.rd != '0);
`else
    wr_en = bus.wen;
`endif
    accept  = bus.rd_req && !bus.stall;
    rd_val1 = (wr_en && (bus.rd == bus.rs1)) ? bus.data : regs[bus.rs1];
    rd_val2 = (wr_en && (bus.rd == bus.rs2)) ? bus.data : regs[bus.rs2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.rd] <= bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q1      <= '0;
      bus.q2      <= '0;
      bus.q_valid <= 1'b0;
    end else begin
      bus.q_valid <= accept;
      if (accept) begin
        bus.q1 <= rd_val1;
        bus.q2 <= rd_val2;
      end
    end
  end

  always_comb begin
    bus.regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      bus.regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_on = 1'b0;

  regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  logic [DW-1:0] m_q1, m_q2;
  bit            m_qv, m_conf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    bit b1, b2;
    b1 = m_busy[bus.rs1] && !(bus.wen && bus.rd == bus.rs1);
    b2 = m_busy[bus.rs2] && !(bus.wen && bus.rd == bus.rs2);
    return bus.rd_req && (b1 || b2);
  endfunction

  function automatic logic [DW-1:0] model_read(input int idx);
    if (ZR && idx == 0) return '0;
    if (bus.wen && int'(bus.rd) == idx) return bus.data;
    return m_regs[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_q1 = '0; m_q2 = '0; m_qv = 1'b0; m_conf = 1'b0;
    end else begin
      bit acc;
      acc  = bus.rd_req && !model_stall();
      m_qv = acc;
      if (acc) begin
        m_q1 = model_read(int'(bus.rs1));
        m_q2 = model_read(int'(bus.rs2));
      end
      m_conf = bus.alloc_en && !(ZR && bus.alloc_rd == 0) && m_busy[bus.alloc_rd]
               && !(bus.wen && bus.rd == bus.alloc_rd);
      if (bus.wen) begin
        if (!(ZR && bus.rd == 0)) m_regs[bus.rd] = bus.data;
        m_busy[bus.rd] = 1'b0;
      end
      if (bus.alloc_en && !(ZR && bus.alloc_rd == 0)) m_busy[bus.alloc_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [NR-1:0]    exp_busy;
      logic [NR*DW-1:0] exp_flat;
      for (int i = 0; i < NR; i++) begin
        exp_busy[i]          = m_busy[i];
        exp_flat[i*DW +: DW] = m_regs[i];
      end
      chk("q_valid", 32'(bus.q_valid), 32'(m_qv));
      if (m_qv) begin
        chk("q1", 32'(bus.q1), 32'(m_q1));
        chk("q2", 32'(bus.q2), 32'(m_q2));
      end
      chk("alloc_conflict", 32'(bus.alloc_conflict), 32'(m_conf));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("regs_flat", 32'(bus.regs_flat), 32'(exp_flat));
      chk("stall", 32'(bus.stall), 32'(model_stall()));
    end
  end

  task automatic idle();
    bus.wen = 1'b0; bus.rd = '0; bus.data = '0;
    bus.rd_req = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
    bus.alloc_en = 1'b0; bus.alloc_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rf;
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    model_on = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_qv", 32'(bus.q_valid), 32'h0);
    chk("rst_flat", 32'(bus.regs_flat), 32'h0);

    // Read after reset
    bus.rd_req = 1'b1; bus.rs1 = 2'd2; bus.rs2 = 2'd3;
    tick();
    chk("rd0_qv", 32'(bus.q_valid), 32'h1);
    chk("rd0_q1", 32'(bus.q1), 32'h00);
    chk("rd0_q2", 32'(bus.q2), 32'h00);

    // Same-cycle write and read of r2
    idle();
    bus.wen = 1'b1; bus.rd = 2'd2; bus.data = 8'hA5;
    bus.rd_req = 1'b1; bus.rs1 = 2'd2; bus.rs2 = 2'd0;
    tick();
    rf = bus.regs_flat;
    chk("byp_q1", 32'(bus.q1), 32'hA5);
    chk("byp_flat", 32'(rf[23:16]), 32'hA5);

    // Allocate r1, consumer stalls until the write lands
    idle();
    bus.alloc_en = 1'b1; bus.alloc_rd = 2'd1;
    tick();
    chk("alloc_busy1", 32'(bus.busy[1]), 32'h1);
    idle();
    bus.rd_req = 1'b1; bus.rs1 = 2'd0; bus.rs2 = 2'd1;
    repeat (3) begin
      #1 chk("stall_hi", 32'(bus.stall), 32'h1);
      tick();
      chk("stall_qv", 32'(bus.q_valid), 32'h0);
    end
    bus.wen = 1'b1; bus.rd = 2'd1; bus.data = 8'h3C;
    #1 chk("stall_drop", 32'(bus.stall), 32'h0);
    tick();
    chk("wake_q2", 32'(bus.q2), 32'h3C);
    chk("wake_qv", 32'(bus.q_valid), 32'h1);
    chk("wake_busy1", 32'(bus.busy[1]), 32'h0);

    // Double allocation of r3
    idle();
    bus.alloc_en = 1'b1; bus.alloc_rd = 2'd3;
    tick();
    chk("conf_first", 32'(bus.alloc_conflict), 32'h0);
    tick();
    chk("conf_pulse", 32'(bus.alloc_conflict), 32'h1);
    chk("conf_busy3", 32'(bus.busy[3]), 32'h1);
    idle();
    tick();
    chk("conf_end", 32'(bus.alloc_conflict), 32'h0);
    chk("conf_busy3b", 32'(bus.busy[3]), 32'h1);

    // Write and allocate r0 together
    bus.wen = 1'b1; bus.rd = 2'd0; bus.data = 8'h5A;
    bus.alloc_en = 1'b1; bus.alloc_rd = 2'd0;
    tick();
    rf = bus.regs_flat;
    chk("r0_data", 32'(rf[7:0]), ZR ? 32'h00 : 32'h5A);
    chk("r0_busy", 32'(bus.busy[0]), ZR ? 32'h0 : 32'h1);

    // Build busy = 1010 with a valid read, then reset
    idle();
    bus.wen = 1'b1; bus.rd = 2'd0; bus.data = 8'h11;
    bus.alloc_en = 1'b1; bus.alloc_rd = 2'd1;
    bus.rd_req = 1'b1; bus.rs1 = 2'd2; bus.rs2 = 2'd2;
    tick();
    chk("pre_busy", 32'(bus.busy), 32'hA);
    chk("pre_qv", 32'(bus.q_valid), 32'h1);
    rst = 1'b1;
    idle();
    bus.rd_req = 1'b1; bus.rs1 = 2'd1; bus.rs2 = 2'd3;
    bus.wen = 1'b1; bus.rd = 2'd2; bus.data = 8'hFF;
    bus.alloc_en = 1'b1; bus.alloc_rd = 2'd2;
    tick();
    rst = 1'b0;
    idle();
    bus.rd_req = 1'b1; bus.rs1 = 2'd1; bus.rs2 = 2'd3;
    chk("post_q1", 32'(bus.q1), 32'h0);
    chk("post_q2", 32'(bus.q2), 32'h0);
    chk("post_qv", 32'(bus.q_valid), 32'h0);
    chk("post_conf", 32'(bus.alloc_conflict), 32'h0);
    chk("post_busy", 32'(bus.busy), 32'h0);
    chk("post_flat", 32'(bus.regs_flat), 32'h0);
    #1 chk("post_stall", 32'(bus.stall), 32'h0);
    tick();

    // Randomized traffic
    repeat (3000) begin
      rst          = ($urandom_range(0, 99) == 0);
      bus.wen      = ($urandom_range(0, 1) == 1);
      bus.rd       = 2'($urandom_range(0, NR - 1));
      bus.data     = 8'($urandom);
      bus.rd_req   = ($urandom_range(0, 3) != 0);
      bus.rs1      = 2'($urandom_range(0, NR - 1));
      bus.rs2      = 2'($urandom_range(0, NR - 1));
      bus.alloc_en = ($urandom_range(0, 2) == 0);
      bus.alloc_rd = 2'($urandom_range(0, NR - 1));
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
